// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: op and state encodings, digit-count helper.
// Pure declarations: no latency, no handshake.
package shifter_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int calc_ndig(input int shamt_w, input int digit_bits);
    return (shamt_w + digit_bits - 1) / digit_bits;
  endfunction

endpackage

// File: rtl/shift_digit_stage.sv
// One radix-2^DIGIT_BITS shift step: applies op to acc by digit_i << (pos_i*DIGIT_BITS).
// Combinational, zero latency; no handshake.
module shift_digit_stage
  import shifter_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter int  DIGIT_BITS = 2,
  localparam int SHAMT_W    = $clog2(WIDTH),
  localparam int NDIG       = calc_ndig(SHAMT_W, DIGIT_BITS),
  localparam int IDX_W      = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic [WIDTH-1:0]      acc_i,
  input  logic [1:0]            op_i,
  input  logic [DIGIT_BITS-1:0] digit_i,
  input  logic [IDX_W-1:0]      pos_i,
  output logic [WIDTH-1:0]      acc_o
);

  logic [SHAMT_W-1:0] amt;

  always_comb begin
    // Upper digit bits beyond SHAMT_W are always zero, so truncation is lossless.
    amt = SHAMT_W'(int'(digit_i) << (int'(pos_i) * DIGIT_BITS));
    case (op_i)
      SH_SLL:  acc_o = acc_i << amt;
      SH_SRL:  acc_o = acc_i >> amt;
      SH_SRA:  acc_o = $unsigned($signed(acc_i) >>> amt);
      default: acc_o = (acc_i << amt) | (acc_i >> (WIDTH - int'(amt)));
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL, one shamt digit per cycle; latency 1..NDIG, early exit on zero upper digits.
// Start accepted only while idle; busy stalls the requester, data_resultRDY pulses once per op.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = $clog2(WIDTH),
  parameter int DIGIT_BITS = 2,
  parameter int NDIG       = calc_ndig(SHAMT_W, DIGIT_BITS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [1:0]         ctrl_op,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY,
  output logic               busy
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PAD_W = NDIG * DIGIT_BITS;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [PAD_W-1:0]      shamt_q, shamt_d;
  logic [1:0]            op_q, op_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rdy_q, rdy_d;
  logic [DIGIT_BITS-1:0] digit;
  logic                  last_digit;
  logic [WIDTH-1:0]      stage_acc;

  shift_digit_stage #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_stage (
    .acc_i   (acc_q),
    .op_i    (op_q),
    .digit_i (digit),
    .pos_i   (idx_q),
    .acc_o   (stage_acc)
  );

  always_comb begin
    digit      = shamt_q[int'(idx_q) * DIGIT_BITS +: DIGIT_BITS];
    // Finish as soon as every digit above the current one is zero.
    last_digit = (int'(idx_q) == NDIG - 1) ||
                 ((shamt_q >> ((int'(idx_q) + 1) * DIGIT_BITS)) == '0);

    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    shamt_d  = shamt_q;
    op_d     = op_q;
    idx_d    = idx_q;
    rdy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          acc_d   = data_operandA;
          shamt_d = PAD_W'(ctrl_shiftamt);
          op_d    = ctrl_op;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      default: begin
        acc_d = stage_acc;
        if (last_digit) begin
          result_d = stage_acc;
          rdy_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      shamt_q  <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      shamt_q  <= shamt_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == ST_BUSY);

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter (WIDTH=32, DIGIT_BITS=2) with hand-computed vectors and a shamt sweep.
module tb_iterative_shifter;
  import shifter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [1:0]  ctrl_op;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  iterative_shifter #(.WIDTH(32), .DIGIT_BITS(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_op        (ctrl_op),
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input int sh);
    case (op)
      SH_SLL:  return a << sh;
      SH_SRL:  return a >> sh;
      SH_SRA:  return $unsigned($signed(a) >>> sh);
      default: return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
    endcase
  endfunction

  function automatic int ref_lat(input int sh);
    return (sh < 4) ? 1 : (sh < 16) ? 2 : 3;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    ctrl_op       = op;
    data_operandA = a;
    ctrl_shiftamt = sh;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start    = 1'b0;
    data_operandA = ~a;
    ctrl_shiftamt = ~sh;
    ctrl_op       = ~op;
    for (int c = 1; c <= 8; c++) begin
      if (busy) busy_cnt++;
      tick();
      if (data_resultRDY) begin
        lat = c;
        break;
      end
    end
    chk({tag, " result"}, data_result, exp_res);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({tag, " busy clear"}, 32'(busy), 32'd0);
    tick();
    chk({tag, " single rdy"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    // Reset with start held high: reset must win.
    reset         = 1'b1;
    ctrl_start    = 1'b1;
    ctrl_op       = SH_SLL;
    data_operandA = 32'hDEAD_BEEF;
    ctrl_shiftamt = 5'd3;
    tick();
    tick();
    chk("reset result", data_result, 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset      = 1'b0;
    ctrl_start = 1'b0;
    tick();
    chk("idle busy", 32'(busy), 32'd0);

    run_op("sll_1_31", SH_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 3);
    run_op("sra_4", SH_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000, 2);
    run_op("srl_4", SH_SRL, 32'h8000_0000, 5'd4, 32'h0800_0000, 2);
    run_op("rol_1", SH_ROL, 32'h8000_0001, 5'd1, 32'h0000_0003, 1);
    run_op("sra_0", SH_SRA, 32'h9234_5678, 5'd0, 32'h9234_5678, 1);
    run_op("rol_0", SH_ROL, 32'h9234_5678, 5'd0, 32'h9234_5678, 1);

    // Start while busy is ignored; start on the RDY cycle is accepted.
    ctrl_op = SH_SLL; data_operandA = 32'h0000_00FF; ctrl_shiftamt = 5'd8; ctrl_start = 1'b1;
    tick();
    chk("b2b accept busy", 32'(busy), 32'd1);
    ctrl_op = SH_SRL; data_operandA = 32'hFFFF_FFFF; ctrl_shiftamt = 5'd1;
    tick();
    chk("b2b ignored rdy", 32'(data_resultRDY), 32'd0);
    chk("b2b ignored busy", 32'(busy), 32'd1);
    tick();
    chk("b2b first rdy", 32'(data_resultRDY), 32'd1);
    chk("b2b first result", data_result, 32'h0000_FF00);
    tick();
    ctrl_start = 1'b0;
    chk("b2b second accept busy", 32'(busy), 32'd1);
    chk("b2b second rdy low", 32'(data_resultRDY), 32'd0);
    chk("b2b result held", data_result, 32'h0000_FF00);
    tick();
    chk("b2b second rdy", 32'(data_resultRDY), 32'd1);
    chk("b2b second result", data_result, 32'h7FFF_FFFF);
    tick();
    chk("b2b end rdy", 32'(data_resultRDY), 32'd0);
    chk("b2b end busy", 32'(busy), 32'd0);

    // Reset in the second busy cycle of a 3-cycle op aborts it.
    ctrl_op = SH_SLL; data_operandA = 32'h0000_0001; ctrl_shiftamt = 5'd31; ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort rdy", 32'(data_resultRDY), 32'd0);
    chk("abort result", data_result, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    tick();
    chk("abort no late rdy", 32'(data_resultRDY), 32'd0);
    tick();
    chk("abort no late rdy2", 32'(data_resultRDY), 32'd0);
    run_op("after_abort", SH_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F, 2);

    for (int op = 0; op < 4; op++) begin
      for (int sh = 0; sh < 32; sh++) begin
        run_op($sformatf("sweep op%0d sh%0d", op, sh), 2'(op), 32'hA5A5_A5A5, 5'(sh),
               ref_shift(2'(op), 32'hA5A5_A5A5, sh), ref_lat(sh));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Parametrised, multi-cycle shift unit for the processor execute stage.
- Supports SLL, SRL, SRA and ROL on a WIDTH-bit operand.
- Processes the shift amount one radix-2^DIGIT_BITS digit per cycle, with early termination once the remaining digits are zero.
- Uses a start/ready handshake in the same style as the multdiv unit, so the pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand/result width. Power of two, at least 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; do not override).
- DIGIT_BITS, 2: shamt bits consumed per cycle. Range 1..SHAMT_W.
- NDIG, ceil(SHAMT_W/DIGIT_BITS): digit count, i.e. maximum latency in cycles (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  request. Sampled only when busy=0.
- ctrl_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- data_operandA  in  WIDTH  operand, captured on an accepted start.
- ctrl_shiftamt  in  SHAMT_W  shift amount, captured on an accepted start.
- data_result  out  WIDTH  result. Held until the next result is produced.
- data_resultRDY  out  1  one-cycle pulse: data_result is valid.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Reset: everything clears at the next rising edge while reset=1.
  - data_result=0, data_resultRDY=0, busy=0, state=IDLE.
  - Internal registers cleared, digit index=0.
  - Reset overrides start.
- States: IDLE, BUSY.
  - A DONE condition is expressed as the data_resultRDY pulse, not a separate wait state.
- IDLE with ctrl_start=1 at edge e0:
  - Latch operand into the working register (acc).
  - Latch shamt and op; set idx=0; go to BUSY; busy=1 from the cycle after e0.
- BUSY, each edge:
  - Compute d = shamt[idx*DIGIT_BITS +: DIGIT_BITS]. The top digit is zero-extended if SHAMT_W is not a multiple of DIGIT_BITS.
  - Update acc = op(acc, d << (idx*DIGIT_BITS)).
  - If idx==NDIG-1 or all shamt bits above digit idx are zero: data_result <= new acc, data_resultRDY <= 1, go to IDLE, busy <= 0.
  - Otherwise idx <= idx+1.
- Latency: data_resultRDY is high in cycle e0+k, where k = index of the highest non-zero digit + 1 (minimum 1, maximum NDIG).
  - Default params: shamt 0..3 gives 1 cycle, 4..15 gives 2 cycles, 16..31 gives 3 cycles.
- data_resultRDY is high for exactly one cycle per operation.
- Back-to-back: ctrl_start may be asserted in the same cycle data_resultRDY=1 (the unit is IDLE). It is accepted; the previous data_result stays valid until overwritten.
- ctrl_start while busy=1: ignored, no queueing. Inputs are not re-sampled mid-operation, so operand/shamt/op may change freely after acceptance.
- Arithmetic:
  - SLL: zero fill on the right.
  - SRL: zero fill on the left.
  - SRA: sign fill from acc[WIDTH-1]. This equals the original MSB because MSB is preserved stepwise.
  - ROL: bits leaving the MSB re-enter at the LSB. Per-digit rotations compose exactly.
  - Shift amounts never reach WIDTH: the SHAMT_W bound applies, with no modulo surprises.
- Reset mid-operation: aborts, no RDY pulse, data_result=0.
- Undefined ctrl_op values: none (2-bit encoding is fully defined).

Decomposition:
- Shared package shifter_pkg:
  - Op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROL=2'b11.
  - State encoding for IDLE/BUSY.
  - Helper function computing NDIG.
- One natural sub-module, shift_digit_stage:
  - Combinational; parameters WIDTH and DIGIT_BITS.
  - Inputs: acc, op, digit value, digit position.
  - Output: shifted acc.
  - Instantiated once and reused each cycle.
- The top level holds the FSM, idx counter, early-termination detect and output registers.

Test Plan:
- SLL, A=0x00000001, shamt=31 -> data_result=0x80000000, RDY exactly 3 cycles after start, busy high 3 cycles.
- SRA, A=0x80000000, shamt=4 -> 0xF8000000 after 2 cycles. SRL same inputs -> 0x08000000 after 2 cycles.
- ROL, A=0x80000001, shamt=1 -> 0x00000003 after 1 cycle. shamt=0 on any op -> result=A after 1 cycle.
- Start SLL A=0xFF shamt=8 (-> 0x0000FF00), then pulse start with different inputs while busy -> ignored; single RDY with 0x0000FF00. Start asserted on the RDY cycle -> accepted.
- Assert reset during cycle 2 of a shamt=31 op -> no RDY pulse, data_result=0, busy=0 next cycle. A new start afterwards completes normally.
- Sweep shamt 0..31 for all four ops with A=0xA5A5A5A5 against a reference model; check latency matches the highest non-zero digit rule.
